// File: rtl/if_id_pipe_pkg.sv
// Shared widths, bubble encoding and stage-state encoding for the IF/ID
// pipeline boundary and later stage boundaries built from the same block.
package if_id_pipe_pkg;

  localparam int unsigned ImmWidth  = 64;
  localparam int unsigned InstWidth = 32;

  // addi x0,x0,0
  localparam logic [InstWidth-1:0] NopInst = 32'h0000_0013;

  localparam int unsigned SkidSingle   = 0;
  localparam int unsigned SkidTwoEntry = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipeState_e;

endpackage

// File: rtl/if_id_pipe_data_reg.sv
// Payload register: synchronous reset, write enable and a synchronous clear
// back to the reset value, so flushed stages read as bubbles.
module pipe_data_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RESET_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: valid/ready handshake, flush-to-bubble, optional
// two-entry skid buffer and a saturating stall counter.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int unsigned       PC_W     = ImmWidth,
  parameter int unsigned       INST_W   = InstWidth,
  parameter int unsigned       SKID     = SkidTwoEntry,
  parameter logic [PC_W-1:0]   PC_RESET = '0,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NopInst),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned      PayW   = PC_W + INST_W;
  localparam logic [PayW-1:0]  Bubble = {PC_RESET, NOP_INST};

  pipeState_e      state, stateNext;
  logic            inFire, outFire;
  logic            mainWe, mainClr, mainFromSkid, skidWe, skidClr;
  logic [PayW-1:0] inPay, mainD, mainQ, skidQ;

  assign inPay     = {in_pc, in_inst};
  assign out_valid = (state != EMPTY);
  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;
  assign mainD     = mainFromSkid ? skidQ : inPay;
  assign {out_pc, out_inst} = mainQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Both modes share this FSM; with the combinational in_ready of the
  // single-entry mode an in fire in ONE always coincides with an out fire,
  // so FULL is unreachable there and the old valid-bit behaviour results.
  always_comb begin
    stateNext    = state;
    mainWe       = 1'b0;
    mainClr      = 1'b0;
    mainFromSkid = 1'b0;
    skidWe       = 1'b0;
    skidClr      = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
      mainClr   = 1'b1;
      skidClr   = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (inFire) begin
            stateNext = ONE;
            mainWe    = 1'b1;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mainWe = 1'b1;
          end else if (inFire) begin
            stateNext = FULL;
            skidWe    = 1'b1;
          end else if (outFire) begin
            stateNext = EMPTY;
            mainClr   = 1'b1;
          end
        end
        FULL: begin
          if (outFire) begin
            stateNext    = ONE;
            mainWe       = 1'b1;
            mainFromSkid = 1'b1;
            skidClr      = 1'b1;
          end
        end
        default: begin
          stateNext = EMPTY;
          mainClr   = 1'b1;
          skidClr   = 1'b1;
        end
      endcase
    end
  end

  pipe_data_reg #(
    .WIDTH    (PayW),
    .RESET_VAL(Bubble)
  ) uMain (
    .clk(clk),
    .rst(rst),
    .clr(mainClr),
    .we (mainWe),
    .d  (mainD),
    .q  (mainQ)
  );

  if (SKID == SkidTwoEntry) begin : gSkid
    logic inReadyQ;

    pipe_data_reg #(
      .WIDTH    (PayW),
      .RESET_VAL(Bubble)
    ) uSkid (
      .clk(clk),
      .rst(rst),
      .clr(skidClr),
      .we (skidWe),
      .d  (inPay),
      .q  (skidQ)
    );

    // Registered copy of (state != FULL): keeps out_ready off the in_ready path.
    always_ff @(posedge clk) begin
      if (rst) begin
        inReadyQ <= 1'b1;
      end else begin
        inReadyQ <= (stateNext != FULL);
      end
    end

    assign in_ready = inReadyQ;
  end else begin : gNoSkid
    assign skidQ    = Bubble;
    assign in_ready = ~out_valid | out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: three instances (skid/16-bit, no-skid/16-bit,
// skid/4-bit counter) share stimulus, each tracked by a queue-level model.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [63:0] inPc = '0;
  logic [31:0] inInst = '0;

  logic        inReady0, inReady1, inReady2;
  logic        outValid0, outValid1, outValid2;
  logic [63:0] outPc0, outPc1, outPc2;
  logic [31:0] outInst0, outInst1, outInst2;
  logic [15:0] stall0, stall1;
  logic [3:0]  stall2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.PC_W(64), .INST_W(32), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady0),
    .in_pc(inPc), .in_inst(inInst), .out_valid(outValid0), .out_ready(outReady),
    .out_pc(outPc0), .out_inst(outInst0), .stall_cnt(stall0));

  if_id_pipe #(.PC_W(64), .INST_W(32), .SKID(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady1),
    .in_pc(inPc), .in_inst(inInst), .out_valid(outValid1), .out_ready(outReady),
    .out_pc(outPc1), .out_inst(outInst1), .stall_cnt(stall1));

  if_id_pipe #(.PC_W(64), .INST_W(32), .SKID(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady2),
    .in_pc(inPc), .in_inst(inInst), .out_valid(outValid2), .out_ready(outReady),
    .out_pc(outPc2), .out_inst(outInst2), .stall_cnt(stall2));

  // Reference model: per instance an ordered list of held beats (capacity 2
  // with skid, 1 without) and a saturating stall count.
  int unsigned skidOf[3] = '{1, 0, 1};
  int unsigned satOf[3]  = '{65535, 65535, 15};
  int unsigned mLen[3]   = '{0, 0, 0};
  int unsigned mCnt[3]   = '{0, 0, 0};
  logic [95:0] mBuf[3][2];

  function automatic logic expReady(int i);
    if (skidOf[i] != 0) return mLen[i] < 2;
    return (mLen[i] == 0) || outReady;
  endfunction

  // {valid, ready, pc[63:0], inst[31:0], stall[15:0]}
  function automatic logic [113:0] expOf(int i);
    logic [95:0] pay;
    pay = (mLen[i] != 0) ? mBuf[i][0] : {64'h0, 32'h0000_0013};
    return {mLen[i] != 0, expReady(i), pay, 16'(mCnt[i])};
  endfunction

  function automatic logic [113:0] obsOf(int i);
    case (i)
      0:       return {outValid0, inReady0, outPc0, outInst0, stall0};
      1:       return {outValid1, inReady1, outPc1, outInst1, stall1};
      default: return {outValid2, inReady2, outPc2, outInst2, 12'h0, stall2};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic vld, rdy, inF, outF;
      vld  = (mLen[i] != 0);
      rdy  = expReady(i);
      inF  = inValid && rdy;
      outF = vld && outReady;
      if (rst) begin
        mLen[i] = 0;
        mCnt[i] = 0;
      end else begin
        if (vld && !outReady && mCnt[i] < satOf[i]) mCnt[i]++;
        if (outF) begin
          mBuf[i][0] = mBuf[i][1];
          mLen[i]--;
        end
        if (flush) mLen[i] = 0;
        else if (inF) begin
          mBuf[i][mLen[i]] = {inPc, inInst};
          mLen[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b1; outReady = 1'b0; flush = 1'b0;
    inPc = 64'h1234; inInst = 32'hdead_beef;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== {1'b0, 1'b1, 64'h0, 32'h0000_0013, 16'h0}) begin
          errors++;
          $display("FAIL reset_hold dut%0d got=%h exp=%h", i, obsOf(i),
                   {1'b0, 1'b1, 64'h0, 32'h0000_0013, 16'h0});
        end
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obsOf(i) !== {1'b0, 1'b1, 64'h0, 32'h0000_0013, 16'h0}) begin
        errors++;
        $display("FAIL reset_after dut%0d got=%h", i, obsOf(i));
      end
    end
    inValid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [113:0] o;
    outReady = 1'b1; inValid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inPc = 64'h8000_0000 + 64'(4 * k); inInst = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== expOf(i)) begin
          errors++;
          $display("FAIL stream_model dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        o = obsOf(i);
        checks++;
        if ({o[113], o[111:48]} !== {1'b1, 64'h8000_0000 + 64'(4 * k)}) begin
          errors++;
          $display("FAIL stream_latency dut%0d got=%h exp=%h", i, {o[113], o[111:48]},
                   {1'b1, 64'h8000_0000 + 64'(4 * k)});
        end
      end
    end
    inValid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obsOf(i) !== expOf(i)) begin
        errors++;
        $display("FAIL stream_drain dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] base;
    int unsigned n, nextOut, accepted, cntBase;
    logic fired;
    base = 64'h9000_0000; n = 0; nextOut = 0; accepted = 0;
    outReady = 1'b1; inValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        outReady = 1'b0;
        cntBase  = mCnt[0];
      end
      if (c == 7) begin
        outReady = 1'b1;
        inValid  = 1'b0;
        checks++;
        if (accepted != 1 || inReady0 !== 1'b0) begin
          errors++;
          $display("FAIL bp_absorb accepted=%0d in_ready=%b exp accepted=1 in_ready=0",
                   accepted, inReady0);
        end
        checks++;
        if (32'(stall0) !== cntBase + 5) begin
          errors++;
          $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall0, cntBase + 5);
        end
      end
      inPc = base + 64'(4 * n); inInst = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== expOf(i)) begin
          errors++;
          $display("FAIL bp_model dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
        end
      end
      if (outValid0 && outReady) begin
        checks++;
        if (outPc0 !== base + 64'(4 * nextOut)) begin
          errors++;
          $display("FAIL bp_order got=%h exp=%h", outPc0, base + 64'(4 * nextOut));
        end
        nextOut++;
      end
      fired = inValid && inReady0;
      tick();
      if (fired) begin
        n++;
        if (!outReady) accepted++;
      end
    end
    checks++;
    if (nextOut != n || outValid0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_lost delivered=%0d accepted=%0d valid=%b", nextOut, n, outValid0);
    end
  endtask

  task automatic test_flush_full();
    logic [113:0] o;
    outReady = 1'b0; inValid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      inPc = 64'hA000_0000 + 64'(4 * c); inInst = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== expOf(i)) begin
          errors++;
          $display("FAIL flush_fill dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
        end
      end
      tick();
    end
    checks++;
    if (inReady0 !== 1'b0 || outPc0 !== 64'hA000_0000) begin
      errors++;
      $display("FAIL flush_full_state in_ready=%b pc=%h exp 0 a0000000", inReady0, outPc0);
    end
    flush = 1'b1; inPc = 64'hBAD0_0000; inInst = $urandom;
    tick();
    flush = 1'b0; inValid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = obsOf(i);
      checks++;
      if (o[113:16] !== {1'b0, 1'b1, 64'h0, 32'h0000_0013}) begin
        errors++;
        $display("FAIL flush_bubble dut%0d got=%h", i, o[113:16]);
      end
      checks++;
      if (obsOf(i) !== expOf(i)) begin
        errors++;
        $display("FAIL flush_model dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
      end
    end
    inValid = 1'b1; inPc = 64'hC000_0000; inInst = 32'h0051_8193;
    tick();
    inValid = 1'b0;
    #1;
    checks++;
    if ({outValid0, outPc0, outInst0} !== {1'b1, 64'hC000_0000, 32'h0051_8193}) begin
      errors++;
      $display("FAIL flush_next_beat got=%b %h %h exp 1 c0000000 00518193",
               outValid0, outPc0, outInst0);
    end
    outReady = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    outReady = 1'b0; inValid = 1'b1; inPc = 64'hD000_0000; inInst = $urandom;
    tick();
    inValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== expOf(i)) begin
          errors++;
          $display("FAIL sat_model dut%0d got=%h exp=%h", i, obsOf(i), expOf(i));
        end
      end
      tick();
    end
    checks++;
    if (stall2 !== 4'd15) begin
      errors++;
      $display("FAIL sat_stop got=%0d exp=15", stall2);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall2 !== 4'd15 || outValid2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_after_flush cnt=%0d valid=%b exp cnt=15 valid=0", stall2, outValid2);
    end
  endtask

  task automatic test_same_edge();
    outReady = 1'b1; inValid = 1'b1; inPc = 64'hE000_0000; inInst = 32'h1111_1111;
    tick();
    inPc = 64'hE000_0004; inInst = 32'h2222_2222;
    #1;
    checks++;
    if ({outValid1, inReady1, outPc1} !== {1'b1, 1'b1, 64'hE000_0000}) begin
      errors++;
      $display("FAIL same_edge_pre got=%b %b %h exp 1 1 e0000000", outValid1, inReady1, outPc1);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if ({outValid1, outPc1, outInst1} !== {1'b1, 64'hE000_0004, 32'h2222_2222}) begin
      errors++;
      $display("FAIL same_edge_replace got=%b %h %h exp 1 e0000004 22222222",
               outValid1, outPc1, outInst1);
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned bias;
    for (int c = 0; c < 600; c++) begin
      bias     = ((c / 40) % 2 == 0) ? 3 : 1;
      rst      = ($urandom_range(0, 149) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      inValid  = $urandom_range(0, 3) != 0;
      outReady = $urandom_range(0, 3) < bias;
      inPc     = {$urandom, $urandom};
      inInst   = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obsOf(i) !== expOf(i)) begin
          errors++;
          $display("FAIL random_model cyc=%0d dut%0d got=%h exp=%h", c, i, obsOf(i), expOf(i));
        end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; inValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_saturation();
    test_same_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
